// File: rtl/gpio_debounce_chan.sv
// One input channel: two-flop synchroniser, tick-driven debounce counter,
// registered edge pulses and a sticky pending flag.
module gpio_debounce_chan #(
    parameter int   DEBOUNCE_TICKS = 10,
    parameter int   CNT_W          = 5,
    parameter logic INIT           = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pad_i,
    input  logic tick_i,
    input  logic irq_en_i,
    input  logic pend_clr_i,
    output logic gpio_o,
    output logic rise_o,
    output logic fall_o,
    output logic pending_o,
    output logic irq_d_o
);
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, fall_q;
    logic             pend_q, pend_d;

    // Any cycle where the synchronised pin agrees with the stable level
    // throws away accumulated progress, tick or not.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Set dominates clear so an edge arriving with a clear is never lost.
    assign pend_d  = ((rise_q | fall_q) & irq_en_i) | (pend_q & ~pend_clr_i);
    assign irq_d_o = pend_d & irq_en_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= INIT;
            sync2_q  <= INIT;
            stable_q <= INIT;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            sync1_q  <= pad_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= stable_d & ~stable_q;
            fall_q   <= ~stable_d & stable_q;
            pend_q   <= pend_d;
        end
    end

    assign gpio_o    = stable_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pending_o = pend_q;
endmodule

// File: rtl/gpio_input_debounce.sv
// Board-level GPIO input conditioner: shared debounce tick prescaler feeding
// WIDTH independent channels, plus a single level interrupt.
module gpio_input_debounce #(
    parameter int               WIDTH          = 8,
    parameter int               TICK_DIV       = 24000,
    parameter int               DEBOUNCE_TICKS = 10,
    parameter logic [WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic [WIDTH-1:0] irq_en_i,
    input  logic [WIDTH-1:0] pend_clr_i,
    output logic [WIDTH-1:0] pending_o,
    output logic             irq_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int PRE_W = $clog2(TICK_DIV) + 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic [WIDTH-1:0] irq_d;
    logic             irq_q;

    assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    // irq is taken from next-state pending so it tracks pending_o with no lag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            irq_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            irq_q <= |irq_d;
        end
    end

    assign irq_o = irq_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        gpio_debounce_chan #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .CNT_W          (CNT_W),
            .INIT           (INIT_VALUE[i])
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .pad_i      (pad_i[i]),
            .tick_i     (tick),
            .irq_en_i   (irq_en_i[i]),
            .pend_clr_i (pend_clr_i[i]),
            .gpio_o     (gpio_o[i]),
            .rise_o     (rise_o[i]),
            .fall_o     (fall_o[i]),
            .pending_o  (pending_o[i]),
            .irq_d_o    (irq_d[i])
        );
    end
endmodule

// File: tb/tb_gpio_input_debounce.sv
// Randomised and directed bench for gpio_input_debounce against a tick-counting
// reference model (TICK_DIV=4, DEBOUNCE_TICKS=3).
module tb_gpio_input_debounce;
    localparam int T = 4;
    localparam int D = 3;

    logic       clock, reset;
    logic [7:0] pad_i, irq_en_i, pend_clr_i;
    logic [7:0] gpio_o, rise_o, fall_o, pending_o;
    logic       irq_o;
    int         checks = 0;
    int         failures = 0;

    gpio_input_debounce #(
        .WIDTH(8), .TICK_DIV(T), .DEBOUNCE_TICKS(D), .INIT_VALUE(8'h00)
    ) dut (
        .clock(clock), .reset(reset), .pad_i(pad_i), .gpio_o(gpio_o),
        .rise_o(rise_o), .fall_o(fall_o), .irq_en_i(irq_en_i),
        .pend_clr_i(pend_clr_i), .pending_o(pending_o), .irq_o(irq_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: pin delayed two cycles; a new level is accepted at the tick that
    // makes D ticks fall inside one unbroken mismatch run (counted arithmetically).
    typedef struct packed {
        logic [7:0]       s1, s2, gpio, rise, fall, pend;
        logic             irq;
        logic [31:0]      cyc;
        logic [7:0]       run;
        logic [7:0][31:0] start;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(mdl_t c, logic [7:0] pad, logic [7:0] clr, logic [7:0] en);
        mdl_t        n;
        logic        tk;
        logic [31:0] st;
        n     = c;
        n.s1  = pad;
        n.s2  = c.s1;
        n.cyc = c.cyc + 1;
        tk    = (c.cyc % T) == T - 1;
        for (int i = 0; i < 8; i++) begin
            if (c.s2[i] == c.gpio[i]) begin
                n.run[i] = 1'b0;
            end else begin
                st         = c.run[i] ? c.start[i] : c.cyc;
                n.run[i]   = 1'b1;
                n.start[i] = st;
                if (tk && ((c.cyc + 1) / T - st / T) >= D) begin
                    n.gpio[i] = ~c.gpio[i];
                    n.run[i]  = 1'b0;
                end
            end
        end
        n.rise = n.gpio & ~c.gpio;
        n.fall = ~n.gpio & c.gpio;
        n.pend = (c.pend & ~clr) | ((c.rise | c.fall) & en);
        n.irq  = |(n.pend & en);
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m <= '0;
        else       m <= step(m, pad_i, pend_clr_i, irq_en_i);
    end

    task automatic test_reset();
        pad_i = 8'h00; irq_en_i = 8'hFF; pend_clr_i = 8'h00; reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            checks++;
            if ({gpio_o, rise_o, fall_o, pending_o, irq_o} !== 33'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got gpio=%h rise=%h fall=%h pend=%h irq=%b want all zero",
                         k, gpio_o, rise_o, fall_o, pending_o, irq_o);
            end
        end
    endtask

    task automatic test_rise_latency();
        int lat = 0, npulse = 0;
        pad_i[0] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            checks++;
            if ({gpio_o, rise_o, fall_o, pending_o, irq_o} !== {m.gpio, m.rise, m.fall, m.pend, m.irq}) begin
                failures++;
                $display("FAIL model_rise n=%0d got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", n, gpio_o, rise_o,
                         fall_o, pending_o, irq_o, m.gpio, m.rise, m.fall, m.pend, m.irq);
            end
            if (gpio_o[0] && lat == 0) lat = n;
            if (rise_o[0]) npulse++;
        end
        checks++;
        if (lat < 11 || lat > 14) begin
            failures++;
            $display("FAIL rise_latency got %0d want 11..14", lat);
        end
        checks++;
        if (npulse != 1) begin
            failures++;
            $display("FAIL rise_pulse_count got %0d want 1", npulse);
        end
        checks++;
        if (pending_o[0] !== 1'b1 || irq_o !== 1'b1) begin
            failures++;
            $display("FAIL rise_pending got pend0=%b irq=%b want 1 1", pending_o[0], irq_o);
        end
    endtask

    task automatic test_bounce();
        int npulse = 0;
        for (int k = 0; k < 60; k++) begin
            if (k % 3 == 0) pad_i[1] = ~pad_i[1];
            @(negedge clock);
            checks++;
            if (gpio_o[1] !== 1'b0 || rise_o[1] !== 1'b0) begin
                failures++;
                $display("FAIL bounce_hold k=%0d got gpio1=%b rise1=%b want 0 0", k, gpio_o[1], rise_o[1]);
            end
        end
        pad_i[1] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            checks++;
            if ({gpio_o, rise_o, fall_o, pending_o, irq_o} !== {m.gpio, m.rise, m.fall, m.pend, m.irq}) begin
                failures++;
                $display("FAIL model_bounce k=%0d got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", k, gpio_o, rise_o,
                         fall_o, pending_o, irq_o, m.gpio, m.rise, m.fall, m.pend, m.irq);
            end
            if (rise_o[1]) npulse++;
        end
        checks++;
        if (npulse != 1 || gpio_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL bounce_settle got pulses=%0d gpio1=%b want 1 1", npulse, gpio_o[1]);
        end
    endtask

    task automatic test_pend_clr();
        bit seen = 0;
        pend_clr_i = 8'h02;
        @(negedge clock);
        pend_clr_i = 8'h00;
        pad_i[0]   = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clock);
            if (fall_o[0]) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL pend_fall_timeout got no fall0 pulse want one within 40 cycles");
        end
        pend_clr_i[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (pending_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL pend_set_wins got %b want 1", pending_o[0]);
        end
        @(negedge clock);
        pend_clr_i[0] = 1'b0;
        checks++;
        if (pending_o[0] !== 1'b0 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL pend_clear got pend0=%b irq=%b want 0 0", pending_o[0], irq_o);
        end
    endtask

    task automatic test_all_bits();
        int hit = -1;
        pad_i = 8'h00;
        repeat (20) @(negedge clock);
        pend_clr_i = 8'hFF;
        @(negedge clock);
        pend_clr_i = 8'h00; irq_en_i = 8'h00; pad_i = 8'hFF;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            checks++;
            if (irq_o !== 1'b0 || pending_o !== 8'h00) begin
                failures++;
                $display("FAIL all_irq_masked n=%0d got irq=%b pend=%h want 0 00", n, irq_o, pending_o);
            end
            if (hit < 0 && gpio_o != 8'h00) begin
                hit = n;
                checks++;
                if (gpio_o !== 8'hFF || rise_o !== 8'hFF) begin
                    failures++;
                    $display("FAIL all_update got gpio=%h rise=%h want FF FF", gpio_o, rise_o);
                end
            end else if (hit > 0 && n == hit + 1) begin
                checks++;
                if (rise_o !== 8'h00) begin
                    failures++;
                    $display("FAIL all_rise_width got rise=%h want 00", rise_o);
                end
            end
        end
        checks++;
        if (hit < 0) begin
            failures++;
            $display("FAIL all_timeout got gpio=%h want FF within 30 cycles", gpio_o);
        end
    endtask

    task automatic test_reset_midcount();
        int lat = 0;
        irq_en_i = 8'hFF; pad_i = 8'h04;
        repeat (10) @(negedge clock);
        checks++;
        if (gpio_o !== 8'hFF) begin
            failures++;
            $display("FAIL mid_before got gpio=%h want FF", gpio_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (gpio_o !== 8'h00 || rise_o !== 8'h00 || fall_o !== 8'h00 || pending_o !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset got gpio=%h rise=%h fall=%h pend=%h want 00", gpio_o, rise_o, fall_o, pending_o);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (gpio_o[2] && lat == 0) lat = n;
        end
        checks++;
        if (lat < 11 || lat > 14) begin
            failures++;
            $display("FAIL mid_relatency got %0d want 11..14", lat);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                pad_i = $urandom;
                hold  = $urandom_range(1, 20);
            end
            hold--;
            if (k % 50 == 0) irq_en_i = $urandom;
            pend_clr_i = $urandom & $urandom & $urandom;
            @(negedge clock);
            checks++;
            if ({gpio_o, rise_o, fall_o, pending_o, irq_o} !== {m.gpio, m.rise, m.fall, m.pend, m.irq}) begin
                failures++;
                $display("FAIL model_random k=%0d got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", k, gpio_o, rise_o,
                         fall_o, pending_o, irq_o, m.gpio, m.rise, m.fall, m.pend, m.irq);
            end
        end
    endtask

    initial begin
        reset = 1'b1; pad_i = 8'h00; irq_en_i = 8'hFF; pend_clr_i = 8'h00;
        test_reset();
        test_rise_latency();
        test_bounce();
        test_pend_clr();
        test_all_bits();
        test_reset_midcount();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
